// File: rtl/terminal_ingress_queue_pkg.sv
// Shared packet layout and address helpers for the terminal ingress path.
// Field offsets are counted down from the packet MSB so that they work for any pckg_sz.
package terminal_ingress_queue_pkg;

    localparam int NXT_JUMP_W   = 8;
    localparam int ADDR_W       = 4;
    localparam int CNT_W        = 16;

    // Offsets of each field's MSB below the packet MSB.
    localparam int NXT_JUMP_OFS = 0;
    localparam int ROW_OFS      = 8;
    localparam int COL_OFS      = 12;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // A destination is a border terminal: the top or bottom ring (row 0 or rows+1) at an
    // in-range column, or the left or right ring (col 0 or cols+1) at an in-range row.
    // Corners and interior router positions are never valid terminals.
    function automatic logic dest_valid(addr_t row, addr_t col, int rows, int cols);
        int   r;
        int   c;
        logic row_ring;
        logic col_ring;
        r        = int'(row);
        c        = int'(col);
        row_ring = ((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= cols);
        col_ring = ((c == 0) || (c == cols + 1)) && (r >= 1) && (r <= rows);
        return row_ring || col_ring;
    endfunction

    // Event counters stick at all-ones rather than wrapping back to zero.
    function automatic cnt_t sat_inc(cnt_t value, logic en);
        if (en && (value != '1)) begin
            return value + cnt_t'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/terminal_ingress_queue_if.sv
// Source-side and mesh-side handshake of the terminal ingress queue.
interface terminal_ingress_queue_if #(
    parameter int pckg_sz = 40
);
    logic               push;
    logic [pckg_sz-1:0] data_in;
    logic               full;
    logic               pndng_i_in;
    logic [pckg_sz-1:0] data_out_i_in;
    logic               popin;
    logic               drop;

    // The master drives packets in and pops them toward the mesh.
    modport master (
        output push, data_in, popin,
        input  full, pndng_i_in, data_out_i_in, drop
    );

    // The queue itself.
    modport slave (
        input  push, data_in, popin,
        output full, pndng_i_in, data_out_i_in, drop
    );
endinterface

// File: rtl/terminal_ingress_queue_addr_chk.sv
// Combinational destination check: the address must be a border terminal and not ourselves.
module terminal_addr_chk
    import terminal_ingress_queue_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLUMS = 4,
    parameter int id_row = 0,
    parameter int id_col = 1
) (
    input  addr_t row,
    input  addr_t col,
    output logic  addr_ok
);

    // Reject invalid terminals and packets addressed back to this terminal.
    always_comb begin
        addr_ok = dest_valid(row, col, ROWS, COLUMS) &&
                  !((row == ADDR_W'(id_row)) && (col == ADDR_W'(id_col)));
    end

endmodule

// File: rtl/terminal_ingress_queue.sv
// First-word-fall-through ingress queue between a terminal source and the mesh.
// Packets with a bad or self destination are dropped; accepted packets get Nxt_jump cleared.
module terminal_ingress_queue
    import terminal_ingress_queue_pkg::*;
#(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int id_row     = 0,
    parameter int id_col     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    terminal_ingress_queue_if.slave   q_if,
    output cnt_t                      accepted_cnt,
    output cnt_t                      dropped_cnt,
    output cnt_t                      overflow_cnt
);

    localparam int PTR_W = $clog2(fifo_depth);
    localparam int OCC_W = PTR_W + 1;

    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               full_q, full_d;
    logic               drop_q, drop_d;
    cnt_t               accepted_cnt_q, accepted_cnt_d;
    cnt_t               dropped_cnt_q, dropped_cnt_d;
    cnt_t               overflow_cnt_q, overflow_cnt_d;

    logic               addr_ok;
    logic               do_pop;
    logic               do_push;
    logic               do_overflow;
    logic [pckg_sz-1:0] wr_data;

    terminal_addr_chk #(
        .ROWS   (ROWS),
        .COLUMS (COLUMS),
        .id_row (id_row),
        .id_col (id_col)
    ) u_addr_chk (
        .row     (q_if.data_in[pckg_sz-1-ROW_OFS -: ADDR_W]),
        .col     (q_if.data_in[pckg_sz-1-COL_OFS -: ADDR_W]),
        .addr_ok (addr_ok)
    );

    // Classify this cycle's push/pop and compute the next queue and counter state.
    always_comb begin
        // NOTE: every always_comb output is given a value up front so no path can infer a latch.
        wr_data     = q_if.data_in;
        wr_data[pckg_sz-1-NXT_JUMP_OFS -: NXT_JUMP_W] = '0;

        // A pop needs a head; popin on an empty queue is ignored, even alongside a push.
        do_pop      = q_if.popin && (occ_q != '0);
        do_push     = q_if.push && addr_ok && (!full_q || do_pop);
        do_overflow = q_if.push && addr_ok && full_q && !do_pop;
        drop_d      = q_if.push && !addr_ok;

        wr_ptr_d    = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d       = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
        full_d      = (occ_d == OCC_W'(fifo_depth));

        accepted_cnt_d = sat_inc(accepted_cnt_q, do_push);
        dropped_cnt_d  = sat_inc(dropped_cnt_q, drop_d);
        overflow_cnt_d = sat_inc(overflow_cnt_q, do_overflow);
    end

    // Control state and counters; reset empties the queue and clears all statistics.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            full_q         <= 1'b0;
            drop_q         <= 1'b0;
            accepted_cnt_q <= '0;
            dropped_cnt_q  <= '0;
            overflow_cnt_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            full_q         <= full_d;
            drop_q         <= drop_d;
            accepted_cnt_q <= accepted_cnt_d;
            dropped_cnt_q  <= dropped_cnt_d;
            overflow_cnt_q <= overflow_cnt_d;
        end
    end

    // Packet storage, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign q_if.data_out_i_in = mem_q[rd_ptr_q];
    assign q_if.pndng_i_in    = (occ_q != '0);
    assign q_if.full          = full_q;
    assign q_if.drop          = drop_q;
    assign accepted_cnt       = accepted_cnt_q;
    assign dropped_cnt        = dropped_cnt_q;
    assign overflow_cnt       = overflow_cnt_q;

endmodule

// File: tb/tb_terminal_ingress_queue.sv
// Directed bench for terminal_ingress_queue at default parameters (terminal (0,1), 4x4 mesh, depth 4).
module tb_terminal_ingress_queue;

    logic        clk;
    logic        reset;
    logic [15:0] accepted_cnt;
    logic [15:0] dropped_cnt;
    logic [15:0] overflow_cnt;

    int n_checks;
    int n_pass;

    terminal_ingress_queue_if #(.pckg_sz(40)) q_if ();

    terminal_ingress_queue dut (
        .clk          (clk),
        .reset        (reset),
        .q_if         (q_if),
        .accepted_cnt (accepted_cnt),
        .dropped_cnt  (dropped_cnt),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; outputs are observed and inputs changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] mk(input logic [7:0] nj, input logic [3:0] r,
                                       input logic [3:0] c, input logic m,
                                       input logic [22:0] pl);
        return {nj, r, c, m, pl};
    endfunction

    // What the queue should present for an accepted packet: Nxt_jump cleared.
    function automatic logic [39:0] strip(input logic [39:0] p);
        logic [39:0] t;
        t          = p;
        t[39:32]   = 8'h00;
        return t;
    endfunction

    logic [39:0] p   [6];
    logic [39:0] sp  [10];
    logic [3:0]  sr  [10];
    logic [3:0]  sc  [10];
    logic [39:0] rp  [3];
    logic [39:0] q0;

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b0;
        q_if.push     = 1'b0;
        q_if.popin    = 1'b0;
        q_if.data_in  = '0;

        // Reset state.
        repeat (3) tick();
        check("rst_full",     64'(q_if.full),       64'd0);
        check("rst_pndng",    64'(q_if.pndng_i_in), 64'd0);
        check("rst_drop",     64'(q_if.drop),       64'd0);
        check("rst_acc",      64'(accepted_cnt),    64'd0);
        check("rst_drp",      64'(dropped_cnt),     64'd0);
        check("rst_ovf",      64'(overflow_cnt),    64'd0);
        reset = 1'b1;
        tick();

        // Fill: four valid packets to (0,2), no pops.
        for (int i = 0; i < 6; i++) begin
            p[i] = mk(8'hA5 + 8'(i), 4'd0, 4'd2, 1'(i), 23'h1000 + 23'(i));
        end
        for (int i = 0; i < 4; i++) begin
            q_if.push    = 1'b1;
            q_if.data_in = p[i];
            tick();
            if (i == 0) begin
                check("fill_pndng_1cyc", 64'(q_if.pndng_i_in), 64'd1);
                check("fill_head_1cyc",  64'(q_if.data_out_i_in), 64'(strip(p[0])));
            end
        end
        q_if.push = 1'b0;
        check("fill_full",  64'(q_if.full),          64'd1);
        check("fill_acc",   64'(accepted_cnt),       64'd4);
        check("fill_pndng", 64'(q_if.pndng_i_in),    64'd1);
        check("fill_nj0",   64'(q_if.data_out_i_in), 64'(strip(p[0])));

        // Overflow while full, then push with a same-cycle pop.
        q_if.push    = 1'b1;
        q_if.data_in = p[4];
        tick();
        check("ovf_cnt",  64'(overflow_cnt),       64'd1);
        check("ovf_acc",  64'(accepted_cnt),       64'd4);
        check("ovf_head", 64'(q_if.data_out_i_in), 64'(strip(p[0])));
        q_if.data_in = p[5];
        q_if.popin   = 1'b1;
        tick();
        q_if.push  = 1'b0;
        q_if.popin = 1'b0;
        check("pp_acc",  64'(accepted_cnt),       64'd5);
        check("pp_full", 64'(q_if.full),          64'd1);
        check("pp_ovf",  64'(overflow_cnt),       64'd1);
        check("pp_head", 64'(q_if.data_out_i_in), 64'(strip(p[1])));

        // Drain: p1..p3 then p5 in order; p4 was discarded.
        for (int i = 0; i < 4; i++) begin
            q0 = (i == 3) ? p[5] : p[i+1];
            check("drain_pndng", 64'(q_if.pndng_i_in),    64'd1);
            check("drain_head",  64'(q_if.data_out_i_in), 64'(strip(q0)));
            q_if.popin = 1'b1;
            tick();
            q_if.popin = 1'b0;
            if (i == 0) check("drain_notfull", 64'(q_if.full), 64'd0);
        end
        check("drain_empty", 64'(q_if.pndng_i_in), 64'd0);

        // Pop on empty has no effect.
        q_if.popin = 1'b1;
        tick();
        q_if.popin = 1'b0;
        check("emptypop_pndng", 64'(q_if.pndng_i_in), 64'd0);
        check("emptypop_acc",   64'(accepted_cnt),    64'd5);

        // Drops: self (0,1), interior (2,2), corners (0,0) and (5,5).
        q_if.push    = 1'b1;
        q_if.data_in = mk(8'h11, 4'd0, 4'd1, 1'b0, 23'h7);
        tick();
        check("drop_self",  64'(q_if.drop),       64'd1);
        check("drop_cnt1",  64'(dropped_cnt),     64'd1);
        q_if.data_in = mk(8'h22, 4'd2, 4'd2, 1'b1, 23'h8);
        tick();
        check("drop_inner", 64'(q_if.drop),       64'd1);
        check("drop_cnt2",  64'(dropped_cnt),     64'd2);
        check("drop_pndng", 64'(q_if.pndng_i_in), 64'd0);
        q_if.data_in = mk(8'h33, 4'd0, 4'd0, 1'b0, 23'h9);
        tick();
        q_if.data_in = mk(8'h44, 4'd5, 4'd5, 1'b0, 23'hA);
        tick();
        q_if.push = 1'b0;
        check("drop_corner_cnt", 64'(dropped_cnt), 64'd4);
        tick();
        check("drop_pulse_end", 64'(q_if.drop),       64'd0);
        check("drop_acc",       64'(accepted_cnt),    64'd5);
        check("drop_pndng2",    64'(q_if.pndng_i_in), 64'd0);

        // Streaming: ten valid pushes with popin held high, one packet in flight at a time.
        sr = '{4'd0, 4'd5, 4'd1, 4'd4, 4'd0, 4'd5, 4'd2, 4'd3, 4'd0, 4'd5};
        sc = '{4'd4, 4'd1, 4'd0, 4'd5, 4'd2, 4'd4, 4'd0, 4'd5, 4'd3, 4'd2};
        for (int i = 0; i < 10; i++) begin
            sp[i] = mk(8'hF0 | 8'(i), sr[i], sc[i], 1'(i), 23'h55000 + 23'(i * 3));
        end
        q_if.popin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q_if.push    = 1'b1;
            q_if.data_in = sp[i];
            tick();
            check("stream_head",  64'(q_if.data_out_i_in), 64'(strip(sp[i])));
            check("stream_pndng", 64'(q_if.pndng_i_in),    64'd1);
        end
        q_if.push = 1'b0;
        tick();
        q_if.popin = 1'b0;
        check("stream_empty", 64'(q_if.pndng_i_in), 64'd0);
        check("stream_acc",   64'(accepted_cnt),    64'd15);
        check("stream_drp",   64'(dropped_cnt),     64'd4);

        // Reset with three packets queued, then a fresh push.
        for (int i = 0; i < 3; i++) begin
            rp[i]        = mk(8'h0F, 4'd1, 4'd0, 1'b1, 23'h2000 + 23'(i));
            q_if.push    = 1'b1;
            q_if.data_in = rp[i];
            tick();
        end
        q_if.push = 1'b0;
        check("prerst_pndng", 64'(q_if.pndng_i_in), 64'd1);
        reset = 1'b0;
        #2;
        check("mrst_pndng", 64'(q_if.pndng_i_in), 64'd0);
        check("mrst_acc",   64'(accepted_cnt),    64'd0);
        check("mrst_drp",   64'(dropped_cnt),     64'd0);
        check("mrst_ovf",   64'(overflow_cnt),    64'd0);
        check("mrst_full",  64'(q_if.full),       64'd0);
        tick();
        reset = 1'b1;
        tick();
        q0           = mk(8'h77, 4'd3, 4'd5, 1'b0, 23'h3ABCD);
        q_if.push    = 1'b1;
        q_if.data_in = q0;
        tick();
        q_if.push = 1'b0;
        check("post_pndng", 64'(q_if.pndng_i_in),    64'd1);
        check("post_head",  64'(q_if.data_out_i_in), 64'(strip(q0)));
        check("post_acc",   64'(accepted_cnt),       64'd1);
        q_if.popin = 1'b1;
        tick();
        q_if.popin = 1'b0;
        check("post_only_one", 64'(q_if.pndng_i_in), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
